wb_retire_stage: RTL and testbench

Write-back and retirement stage of the MIPS-Lite 5-stage pipeline; sits directly downstream of the memory-access stage. It latches the MEM/WB pipeline register and selects load data or ALU result. It commits that value to the 32-entry register file, which it owns and exposes to decode through two read ports, and maintains the simulator's retired-instruction statistics and halt status.

---
 rtl/wb_retire_stage_if.sv | 43 ++++
 rtl/wb_retire_stage.sv | 140 ++++++++++++++
 tb/tb_wb_retire_stage.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_retire_stage_if.sv
// Bundle between the memory-access stage / decode and the write-back/retire stage.
// master = upstream pipeline side, slave = wb_retire_stage.
interface wb_retire_stage_if #(
    parameter int DATA      = 32,
    parameter int REG_ADDR  = 5,
    parameter int CNT_WIDTH = 32
);
    logic                 valid_in;
    logic [5:0]           opcode_in;
    logic                 reg_write_in;
    logic                 mem_to_reg_in;
    logic [REG_ADDR-1:0]  dest_reg_in;
    logic [DATA-1:0]      mem_data_in;
    logic [DATA-1:0]      alu_data_in;
    logic [REG_ADDR-1:0]  rs_addr;
    logic [REG_ADDR-1:0]  rt_addr;
    logic [DATA-1:0]      rs_data;
    logic [DATA-1:0]      rt_data;
    logic                 wb_valid;
    logic [REG_ADDR-1:0]  wb_reg;
    logic [DATA-1:0]      wb_data;
    logic                 wb_we;
    logic                 halted;
    logic [CNT_WIDTH-1:0] arith_count;
    logic [CNT_WIDTH-1:0] logic_count;
    logic [CNT_WIDTH-1:0] mem_count;
    logic [CNT_WIDTH-1:0] ctrl_count;
    logic [CNT_WIDTH-1:0] total_count;

    modport master (
        output valid_in, opcode_in, reg_write_in, mem_to_reg_in, dest_reg_in,
               mem_data_in, alu_data_in, rs_addr, rt_addr,
        input  rs_data, rt_data, wb_valid, wb_reg, wb_data, wb_we, halted,
               arith_count, logic_count, mem_count, ctrl_count, total_count
    );

    modport slave (
        input  valid_in, opcode_in, reg_write_in, mem_to_reg_in, dest_reg_in,
               mem_data_in, alu_data_in, rs_addr, rt_addr,
        output rs_data, rt_data, wb_valid, wb_reg, wb_data, wb_we, halted,
               arith_count, logic_count, mem_count, ctrl_count, total_count
    );
endinterface

// File: rtl/wb_retire_stage.sv
// MIPS-Lite write-back/retire stage: MEM/WB register, 32-entry register file
// with bypassed read ports, retired-instruction statistics and halt tracking.
//
// state      | meaning
// st_run     | retiring instructions normally
// st_halted  | HALT has retired; frozen until rst
module wb_retire_stage #(
    parameter int DATA      = 32,
    parameter int REG_ADDR  = 5,
    parameter int CNT_WIDTH = 32
) (
    input  logic              clock,
    input  logic              rst,
    wb_retire_stage_if.slave  bus
);
    localparam int NREGS = 2 ** REG_ADDR;
    localparam logic [5:0] OP_HALT = 6'h11;

    typedef enum logic {
        st_run,
        st_halted
    } state_t;

    state_t state, state_nxt;

    logic [DATA-1:0]      regfile [NREGS];
    logic                 wb_valid;
    logic [REG_ADDR-1:0]  wb_reg;
    logic [DATA-1:0]      wb_data;
    logic                 wb_we;
    logic [5:0]           wb_opcode;
    logic [CNT_WIDTH-1:0] arith_count, logic_count, mem_count, ctrl_count, total_count;

    logic halted;
    logic accept;
    logic is_arith, is_logic, is_mem, is_ctrl, is_halt;

    always_ff @(posedge clock) begin
        if (rst) state <= st_run;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        halted    = 1'b0;
        case (state)
            st_run: begin
                if (wb_valid && is_halt) state_nxt = st_halted;
            end
            st_halted: begin
                halted = 1'b1;
            end
            default: state_nxt = st_run;
        endcase
    end

    // A HALT sitting in MEM/WB already blocks the next instruction, one cycle
    // before halted itself rises.
    assign accept = bus.valid_in && !halted && !(wb_valid && wb_opcode == OP_HALT);

    always_comb begin
        is_arith = 1'b0;
        is_logic = 1'b0;
        is_mem   = 1'b0;
        is_ctrl  = 1'b0;
        is_halt  = 1'b0;
        case (wb_opcode) inside
            [6'h00:6'h05]: is_arith = 1'b1;
            [6'h06:6'h0B]: is_logic = 1'b1;
            [6'h0C:6'h0D]: is_mem   = 1'b1;
            [6'h0E:6'h10]: is_ctrl  = 1'b1;
            OP_HALT:       is_halt  = 1'b1;
            default:       ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            wb_valid  <= 1'b0;
            wb_reg    <= '0;
            wb_data   <= '0;
            wb_we     <= 1'b0;
            wb_opcode <= '0;
        end else begin
            wb_valid <= accept;
            if (accept) begin
                wb_data   <= bus.mem_to_reg_in ? bus.mem_data_in : bus.alu_data_in;
                wb_reg    <= bus.dest_reg_in;
                wb_we     <= bus.reg_write_in && (bus.dest_reg_in != '0);
                wb_opcode <= bus.opcode_in;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regfile[i] <= '0;
            arith_count <= '0;
            logic_count <= '0;
            mem_count   <= '0;
            ctrl_count  <= '0;
            total_count <= '0;
        end else if (wb_valid) begin
            if (wb_we) regfile[wb_reg] <= wb_data;
            total_count <= total_count + CNT_WIDTH'(1);
            if (is_arith) arith_count <= arith_count + CNT_WIDTH'(1);
            if (is_logic) logic_count <= logic_count + CNT_WIDTH'(1);
            if (is_mem)   mem_count   <= mem_count   + CNT_WIDTH'(1);
            if (is_ctrl)  ctrl_count  <= ctrl_count  + CNT_WIDTH'(1);
        end
    end

    // Commit happens at the end of the cycle, so decode sees the pending value now.
    always_comb begin
        if (bus.rs_addr == '0)
            bus.rs_data = '0;
        else if (wb_valid && wb_we && bus.rs_addr == wb_reg)
            bus.rs_data = wb_data;
        else
            bus.rs_data = regfile[bus.rs_addr];

        if (bus.rt_addr == '0)
            bus.rt_data = '0;
        else if (wb_valid && wb_we && bus.rt_addr == wb_reg)
            bus.rt_data = wb_data;
        else
            bus.rt_data = regfile[bus.rt_addr];
    end

    assign bus.wb_valid    = wb_valid;
    assign bus.wb_reg      = wb_reg;
    assign bus.wb_data     = wb_data;
    assign bus.wb_we       = wb_we;
    assign bus.halted      = halted;
    assign bus.arith_count = arith_count;
    assign bus.logic_count = logic_count;
    assign bus.mem_count   = mem_count;
    assign bus.ctrl_count  = ctrl_count;
    assign bus.total_count = total_count;
endmodule

// File: tb/tb_wb_retire_stage.sv
// Directed self-checking bench for wb_retire_stage.
module tb_wb_retire_stage;
    logic clock = 1'b0;
    logic rst   = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    wb_retire_stage_if #(.DATA(32), .REG_ADDR(5), .CNT_WIDTH(32)) bus ();

    wb_retire_stage #(.DATA(32), .REG_ADDR(5), .CNT_WIDTH(32)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.valid_in      = 1'b0;
        bus.opcode_in     = 6'h3F;
        bus.reg_write_in  = 1'b0;
        bus.mem_to_reg_in = 1'b0;
        bus.dest_reg_in   = 5'd0;
        bus.mem_data_in   = 32'h0;
        bus.alu_data_in   = 32'h0;
    endtask

    task automatic offer(input logic [5:0] op, input logic we, input logic m2r,
                         input logic [4:0] dest, input logic [31:0] mem, input logic [31:0] alu);
        bus.valid_in      = 1'b1;
        bus.opcode_in     = op;
        bus.reg_write_in  = we;
        bus.mem_to_reg_in = m2r;
        bus.dest_reg_in   = dest;
        bus.mem_data_in   = mem;
        bus.alu_data_in   = alu;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        for (int i = 0; i < 12; i++) begin
            offer(6'($urandom_range(0, 16)), 1'b1, 1'($urandom_range(0, 1)),
                  5'($urandom_range(1, 31)), $urandom, $urandom);
            step();
        end
        do_reset();
        checks++;
        if (bus.total_count !== 32'd0 || bus.arith_count !== 32'd0 || bus.logic_count !== 32'd0 ||
            bus.mem_count !== 32'd0 || bus.ctrl_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_counters: total=%0d arith=%0d logic=%0d mem=%0d ctrl=%0d, required all 0",
                     bus.total_count, bus.arith_count, bus.logic_count, bus.mem_count, bus.ctrl_count);
        end
        checks++;
        if (bus.halted !== 1'b0 || bus.wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: halted=%b wb_valid=%b, required 0 0", bus.halted, bus.wb_valid);
        end
        bad = 0;
        for (int a = 1; a < 32; a++) begin
            bus.rs_addr = 5'(a);
            #1;
            if (bus.rs_data !== 32'h0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_regfile: %0d registers nonzero, required 0", bad);
        end
    endtask

    task automatic test_alu_bypass();
        do_reset();
        offer(6'h01, 1'b1, 1'b0, 5'd5, 32'hAAAA_0000, 32'h0000_0007);
        step();
        idle();
        bus.rs_addr = 5'd5;
        #1;
        checks++;
        if (bus.rs_data !== 32'h7 || bus.wb_valid !== 1'b1 || bus.wb_we !== 1'b1) begin
            failures++;
            $display("FAIL alu_bypass: rs_data=%h wb_valid=%b wb_we=%b, required 00000007 1 1",
                     bus.rs_data, bus.wb_valid, bus.wb_we);
        end
        checks++;
        if (bus.total_count !== 32'd0) begin
            failures++;
            $display("FAIL alu_precommit_count: total=%0d, required 0", bus.total_count);
        end
        step();
        checks++;
        if (bus.rs_data !== 32'h7 || bus.wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL alu_regfile: rs_data=%h wb_valid=%b, required 00000007 0", bus.rs_data, bus.wb_valid);
        end
        checks++;
        if (bus.arith_count !== 32'd1 || bus.total_count !== 32'd1) begin
            failures++;
            $display("FAIL alu_counts: arith=%0d total=%0d, required 1 1", bus.arith_count, bus.total_count);
        end
    endtask

    task automatic test_load_r0();
        do_reset();
        offer(6'h0C, 1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 32'h0000_1234);
        step();
        offer(6'h00, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0000_FFFF);
        step();
        idle();
        bus.rs_addr = 5'd3;
        bus.rt_addr = 5'd0;
        #1;
        checks++;
        if (bus.rs_data !== 32'hDEAD_BEEF || bus.mem_count !== 32'd1) begin
            failures++;
            $display("FAIL load_commit: R3=%h mem=%0d, required deadbeef 1", bus.rs_data, bus.mem_count);
        end
        checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_we !== 1'b0 || bus.rt_data !== 32'h0) begin
            failures++;
            $display("FAIL r0_latched: wb_valid=%b wb_we=%b R0=%h, required 1 0 00000000",
                     bus.wb_valid, bus.wb_we, bus.rt_data);
        end
        step();
        checks++;
        if (bus.rt_data !== 32'h0 || bus.arith_count !== 32'd1 || bus.total_count !== 32'd2) begin
            failures++;
            $display("FAIL r0_commit: R0=%h arith=%0d total=%0d, required 00000000 1 2",
                     bus.rt_data, bus.arith_count, bus.total_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.rs_addr = 5'd4;
        bus.rt_addr = 5'd6;
        offer(6'h0A, 1'b1, 1'b0, 5'd4, 32'h0, 32'h0000_AAAA);
        step();
        offer(6'h0D, 1'b0, 1'b0, 5'd4, 32'h0, 32'h0000_1111);
        step();
        checks++;
        if (bus.rs_data !== 32'h0000_AAAA) begin
            failures++;
            $display("FAIL b2b_overlap: R4=%h, required 0000aaaa", bus.rs_data);
        end
        offer(6'h0F, 1'b0, 1'b0, 5'd4, 32'h0, 32'h0000_2222);
        step();
        offer(6'h02, 1'b1, 1'b0, 5'd6, 32'h0, 32'h0000_0030);
        step();
        idle();
        step();
        step();
        checks++;
        if (bus.rs_data !== 32'h0000_AAAA || bus.rt_data !== 32'h0000_0030) begin
            failures++;
            $display("FAIL b2b_regs: R4=%h R6=%h, required 0000aaaa 00000030", bus.rs_data, bus.rt_data);
        end
        checks++;
        if (bus.logic_count !== 32'd1 || bus.mem_count !== 32'd1 || bus.ctrl_count !== 32'd1 ||
            bus.arith_count !== 32'd1 || bus.total_count !== 32'd4) begin
            failures++;
            $display("FAIL b2b_counts: logic=%0d mem=%0d ctrl=%0d arith=%0d total=%0d, required 1 1 1 1 4",
                     bus.logic_count, bus.mem_count, bus.ctrl_count, bus.arith_count, bus.total_count);
        end
    endtask

    task automatic test_unclassified();
        do_reset();
        offer(6'h2A, 1'b1, 1'b0, 5'd9, 32'h0, 32'h0000_0099);
        step();
        idle();
        step();
        bus.rs_addr = 5'd9;
        #1;
        checks++;
        if (bus.total_count !== 32'd1 || bus.arith_count !== 32'd0 || bus.logic_count !== 32'd0 ||
            bus.mem_count !== 32'd0 || bus.ctrl_count !== 32'd0 || bus.rs_data !== 32'h99) begin
            failures++;
            $display("FAIL other_opcode: total=%0d arith=%0d logic=%0d mem=%0d ctrl=%0d R9=%h, required 1 0 0 0 0 00000099",
                     bus.total_count, bus.arith_count, bus.logic_count, bus.mem_count, bus.ctrl_count, bus.rs_data);
        end
    endtask

    task automatic test_halt();
        do_reset();
        offer(6'h11, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        step();
        checks++;
        if (bus.halted !== 1'b0 || bus.wb_valid !== 1'b1) begin
            failures++;
            $display("FAIL halt_latched: halted=%b wb_valid=%b, required 0 1", bus.halted, bus.wb_valid);
        end
        offer(6'h00, 1'b1, 1'b0, 5'd7, 32'h0, 32'h0000_0009);
        step();
        checks++;
        if (bus.halted !== 1'b1 || bus.wb_valid !== 1'b0 || bus.total_count !== 32'd1) begin
            failures++;
            $display("FAIL halt_commit: halted=%b wb_valid=%b total=%0d, required 1 0 1",
                     bus.halted, bus.wb_valid, bus.total_count);
        end
        for (int i = 0; i < 4; i++) step();
        bus.rs_addr = 5'd7;
        #1;
        checks++;
        if (bus.rs_data !== 32'h0 || bus.total_count !== 32'd1 || bus.arith_count !== 32'd0 ||
            bus.halted !== 1'b1 || bus.wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL halt_frozen: R7=%h total=%0d arith=%0d halted=%b wb_valid=%b, required 00000000 1 0 1 0",
                     bus.rs_data, bus.total_count, bus.arith_count, bus.halted, bus.wb_valid);
        end
        do_reset();
        checks++;
        if (bus.halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_clear: halted=%b, required 0", bus.halted);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        offer(6'h07, 1'b1, 1'b0, 5'd2, 32'h0, 32'h0000_0055);
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        bus.rs_addr = 5'd2;
        #1;
        checks++;
        if (bus.rs_data !== 32'h0 || bus.logic_count !== 32'd0 || bus.total_count !== 32'd0 ||
            bus.wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_midflight: R2=%h logic=%0d total=%0d wb_valid=%b, required 00000000 0 0 0",
                     bus.rs_data, bus.logic_count, bus.total_count, bus.wb_valid);
        end
    endtask

    initial begin
        idle();
        bus.rs_addr = 5'd0;
        bus.rt_addr = 5'd0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        test_reset();
        test_alu_bypass();
        test_load_r0();
        test_back_to_back();
        test_unclassified();
        test_halt();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
